// File: rtl/drp_pkg.sv
// Shared DRP definitions: op encodings, engine state encoding, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package drp_pkg;

    localparam int DRP_ADDR_W = 10;
    localparam int DRP_DATA_W = 16;

    // Reserved encoding 3 is executed as a READ.
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2,
        OP_RSVD  = 2'd3
    } drp_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_EN   = 3'd1,
        RD_WAIT = 3'd2,
        WR_EN   = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } drp_state_e;

endpackage

// File: rtl/drp_timeout_ctr.sv
// Wait-state counter with last-cycle flag, plus saturating timeout event counter.
// Latency: last_o is combinational from the registered wait count; counts update next edge.
// Backpressure: none; driven every cycle by the engine FSM.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   clr_i        zero the wait counter
//   inc_i        one more wait cycle elapsed without completion
//   evt_i        a timeout occurred; bump the event counter (saturating)
//   last_o       current wait cycle is the final allowed one
//   evt_cnt_o    saturating timeout event count
module drp_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ERRCNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                inc_i,
    input  logic                evt_i,
    output logic                last_o,
    output logic [ERRCNT_W-1:0] evt_cnt_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Wait cycle n (1-based) sees a count of n-1, so the last allowed cycle is at N-1.
    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]     wait_q, wait_d;
    logic [ERRCNT_W-1:0] evt_q, evt_d;

    always_comb begin
        wait_d = wait_q;
        if (clr_i) begin
            wait_d = '0;
        end else if (inc_i) begin
            wait_d = wait_q + TO_W'(1);
        end
    end

    always_comb begin
        evt_d = evt_q;
        if (evt_i && (evt_q != '1)) begin
            evt_d = evt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            evt_q  <= '0;
        end else begin
            wait_q <= wait_d;
            evt_q  <= evt_d;
        end
    end

    assign last_o    = (wait_q == LAST_CNT);
    assign evt_cnt_o = evt_q;

endmodule

// File: rtl/drp_master.sv
// DRP transaction engine: queued READ / WRITE / RMW requests onto one DRP port.
// Latency: drp_en the cycle after accept; response the cycle after the final drp_rdy or expiry.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
//
// Ports:
//   clk, rst                      DRP clock, async active-high reset
//   req_valid/req_ready           request handshake with op, addr, wdata, mask
//   rsp_valid/rsp_ready           response handshake with rsp_data, rsp_timeout
//   drp_en/we/addr/di, drp_do/rdy DRP primitive port
//   busy, timeout_cnt             status
module drp_master
    import drp_pkg::*;
#(
    parameter int ADDR_W         = DRP_ADDR_W,
    parameter int DATA_W         = DRP_DATA_W,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ERRCNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W-1:0]   req_mask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_timeout,
    output logic                drp_en,
    output logic                drp_we,
    output logic [ADDR_W-1:0]   drp_addr,
    output logic [DATA_W-1:0]   drp_di,
    input  logic [DATA_W-1:0]   drp_do,
    input  logic                drp_rdy,
    output logic                busy,
    output logic [ERRCNT_W-1:0] timeout_cnt
);

    drp_state_e          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                drp_en_q, drp_en_d;
    logic                drp_we_q, drp_we_d;
    logic [ADDR_W-1:0]   drp_addr_q, drp_addr_d;
    logic [DATA_W-1:0]   drp_di_q, drp_di_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic ctr_clr, ctr_inc, ctr_evt, ctr_last;

    drp_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERRCNT_W       (ERRCNT_W)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ctr_clr),
        .inc_i     (ctr_inc),
        .evt_i     (ctr_evt),
        .last_o    (ctr_last),
        .evt_cnt_o (timeout_cnt)
    );

    // The DRP strobes are registered, so each *_EN state is entered with drp_en
    // already set by the transition into it; the state itself drops the strobe.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        rd_d          = rd_q;
        drp_en_d      = 1'b0;
        drp_we_d      = 1'b0;
        drp_addr_d    = drp_addr_q;
        drp_di_d      = drp_di_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_data_d    = rsp_data_q;
        ctr_clr       = 1'b0;
        ctr_inc       = 1'b0;
        ctr_evt       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    wdata_d    = req_wdata;
                    mask_d     = req_mask;
                    drp_addr_d = req_addr;
                    drp_en_d   = 1'b1;
                    if (req_op == OP_WRITE) begin
                        drp_we_d = 1'b1;
                        drp_di_d = req_wdata;
                        state_d  = WR_EN;
                    end else begin
                        state_d  = RD_EN;
                    end
                end
            end
            RD_EN: begin
                ctr_clr = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_rdy) begin
                    rd_d = drp_do;
                    if (op_q == OP_RMW) begin
                        // Write goes out on the same address, still held in drp_addr_q.
                        drp_en_d = 1'b1;
                        drp_we_d = 1'b1;
                        drp_di_d = (drp_do & ~mask_q) | (wdata_q & mask_q);
                        state_d  = WR_EN;
                    end else begin
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_data_d    = drp_do;
                        state_d       = RESP;
                    end
                end else if (ctr_last) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    ctr_evt       = 1'b1;
                    state_d       = RESP;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            WR_EN: begin
                ctr_clr = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (drp_rdy) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = (op_q == OP_RMW) ? rd_q : '0;
                    state_d       = RESP;
                end else if (ctr_last) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    ctr_evt       = 1'b1;
                    state_d       = RESP;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= OP_READ;
            wdata_q       <= '0;
            mask_q        <= '0;
            rd_q          <= '0;
            drp_en_q      <= 1'b0;
            drp_we_q      <= 1'b0;
            drp_addr_q    <= '0;
            drp_di_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            rd_q          <= rd_d;
            drp_en_q      <= drp_en_d;
            drp_we_q      <= drp_we_d;
            drp_addr_q    <= drp_addr_d;
            drp_di_q      <= drp_di_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign drp_en      = drp_en_q;
    assign drp_we      = drp_we_q;
    assign drp_addr    = drp_addr_q;
    assign drp_di      = drp_di_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: doc/drp_master.md
Name: drp_master

Overview:
- Parametrised DRP transaction engine; next generation of the free-running single-address DRP read poller.
- Accepts queued read, write and read-modify-write (RMW) requests over a valid/ready interface.
- Drives the transceiver/MMCM DRP port and returns the read data, or a timeout indication, over a valid/ready response channel.
- Sits between the control/status register logic and any DRP-capable primitive; one instance per DRP port.

Parameters:
- ADDR_W, 10, DRP address width.
- DATA_W, 16, DRP data width.
- TIMEOUT_CYCLES, 1000, maximum wait-state cycles allowed for drp_rdy before abort; legal range >= 1.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width; derived, never overridden.
- ERRCNT_W, 8, width of the saturating timeout event counter.

Ports:
- clk  in  1  DRP clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  2  0=READ, 1=WRITE, 2=RMW, 3=reserved (treated as READ).
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- req_mask  in  DATA_W  RMW bit mask; 1 = take the bit from req_wdata. Ignored for other ops.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  read data (READ/RMW: the value read before modify); 0 for WRITE or timeout.
- rsp_timeout  out  1  transaction aborted on timeout.
- drp_en  out  1  DRP enable, exactly one cycle per access.
- drp_we  out  1  DRP write enable; qualified by drp_en.
- drp_addr  out  ADDR_W  DRP address.
- drp_di  out  DATA_W  DRP write data.
- drp_do  in  DATA_W  DRP read data.
- drp_rdy  in  1  DRP access complete.
- busy  out  1  state != IDLE.
- timeout_cnt  out  ERRCNT_W  saturating count of timeouts.

Behaviour:
- Reset (async): state IDLE; all drp_* outputs 0; rsp_valid, rsp_timeout, rsp_data and timeout_cnt 0; busy 0.
- All outputs are registered except req_ready = (state==IDLE) and busy.
- States:
  - IDLE: on accept, latch op/addr/wdata/mask. READ and RMW go to RD_EN; WRITE goes to WR_EN.
  - RD_EN: drp_en=1, drp_we=0, drp_addr=addr for one cycle; counter cleared; go to RD_WAIT.
  - RD_WAIT: sample drp_rdy each cycle.
    - On drp_rdy, capture drp_do into rd_reg. READ goes to RESP. RMW goes to WR_EN with wr_data = (rd_reg & ~mask) | (wdata & mask).
  - WR_EN: drp_en=1, drp_we=1, drp_di=wr_data for one cycle; go to WR_WAIT.
  - WR_WAIT: on drp_rdy go to RESP.
  - RESP: rsp_valid=1 and all rsp_* fields stable until rsp_ready. rsp_valid & rsp_ready returns to IDLE; rsp_valid is 0 the following cycle.
- Latency: the accept cycle is T0; drp_en is high in T1. With drp_rdy at T1+k (k>=1), rsp_valid rises at T1+k+1 for READ/WRITE. For RMW, the write drp_en is issued the cycle after the read drp_rdy.
- Timeout:
  - In either WAIT state the counter increments on each cycle without drp_rdy.
  - If drp_rdy is absent on the TIMEOUT_CYCLES-th wait cycle, go to RESP with rsp_timeout=1 and rsp_data=0.
  - timeout_cnt increments and saturates at all-ones.
- Simultaneous events:
  - drp_rdy on the final allowed cycle counts as success; rdy wins over timeout.
  - RMW read timeout aborts without issuing the write.
  - A new request is never accepted while rsp_valid is high.
- drp_rdy asserted in IDLE, RD_EN, WR_EN or RESP is ignored and does not alter state or data.
- drp_we returns to 0 whenever drp_en is 0.
- drp_addr and drp_di hold their last values between accesses.
- Reset mid-transaction abandons the access immediately; no response is produced. Any DRP slave completion that arrives after reset is ignored.

Decomposition:
- Package drp_pkg holds:
  - op encodings OP_READ, OP_WRITE, OP_RMW;
  - state encoding IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP;
  - default DRP widths.
- One sub-module, drp_timeout_ctr, holds the clearable wait counter with its expiry flag plus the saturating event counter, parametrised by TIMEOUT_CYCLES and ERRCNT_W.

Test Plan (TIMEOUT_CYCLES=8 in bench):
- READ addr 0x05A; the model returns 0xBEEF with drp_rdy 3 cycles after drp_en -> one drp_en pulse with we=0 and addr=0x05A; rsp_data=0xBEEF, rsp_timeout=0, rsp_valid at T1+4.
- WRITE addr 0x3FF, data 0x1234 -> single drp_en with we=1, di=0x1234; rsp_data=0, rsp_timeout=0.
- RMW addr 0x010, mask 0x00F0, wdata 0x00A0; model holds 0x5555 -> read then write with di=0x55A5; rsp_data=0x5555; exactly 2 drp_en pulses.
- Model never raises drp_rdy -> rsp_timeout=1 after 8 wait cycles, timeout_cnt=1; an RMW variant issues no write pulse. Also assert drp_rdy exactly on wait cycle 8 -> success.
- Hold rsp_ready=0 for 5 cycles with req_valid high -> rsp fields stable, req_ready=0, no new drp_en; one cycle after rsp_valid & rsp_ready, req_ready=1 and the next request is accepted.
- Assert rst during RD_WAIT -> all outputs 0 asynchronously; a later drp_rdy is ignored; the next request completes normally.
